i2c_eeprom_slave: RTL and testbench
===================================

Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C target that emulates a 24C64-style EEPROM: device address match, 1- or 2-byte word address, byte/page write, current-address, random and sequential read.
- Serves as the responder end of the EEPROM I2C link. Usable on-chip as a loopback target for the e2prom master, or as a synthesizable replacement for the behavioural EEPROM model.
- Lives in the sys_clk domain. SCL and SDA are oversampled; there is no SCL-clocked logic.

Parameters:
- SLAVE_ADDR, 7'b1010000, 7-bit device address to match.
- BIT_CTRL, 1'b1, word-address width: 1 = two address bytes (high first), 0 = one byte.
- MEM_DEPTH, 256, bytes of internal RAM. Must be a power of 2.
- PAGE_SIZE, 32, page-write wrap size. Must be a power of 2 and ≤ MEM_DEPTH.

Ports:
- sys_clk  in  1  system clock (50 MHz nominal).
- sys_rst_n  in  1  asynchronous active-low reset.
- iic_scl  in  1  I2C clock from the master.
- iic_sda_i  in  1  SDA level as seen on the pad.
- iic_sda_oe  out  1  1 = pull SDA low. The wrapper drives the pad low when set, otherwise Z.
- busy  out  1  high from a matched START until STOP or NACK.
- wr_pulse  out  1  one-cycle pulse per byte committed to RAM.

Behaviour:
- Reset: iic_sda_oe=0, busy=0, wr_pulse=0, state=IDLE, address pointer=0. RAM contents are not reset.
- Input conditioning:
  - 2-FF synchroniser plus one history FF on both SCL and SDA.
  - scl_rise/scl_fall/sda_rise/sda_fall are one-cycle strobes.
  - Each SCL high and low phase must last ≥ 8 sys_clk.
- Bus conditions:
  - START = sda_fall while SCL high.
  - STOP = sda_rise while SCL high.
  - These take priority over every state. START (including repeated START) → DEV_ADDR with the bit counter cleared. STOP → IDLE with SDA released.
- Bit timing:
  - Receive bits are shifted MSB-first on scl_rise.
  - iic_sda_oe changes only one cycle after scl_fall, giving hold time.
  - The ACK/data bit is released on the scl_fall that ends the ACK/bit slot.
- States:
  - IDLE: waits for START.
  - DEV_ADDR: 8 bits. On match with R/W=0 → ACK_DEV → ADDR_H (BIT_CTRL=1) or ADDR_L. On match with R/W=1 → ACK_DEV → RD_DATA. On mismatch → no ACK, → IDLE, busy=0.
  - ADDR_H / ADDR_L: 8 bits each, each ACKed. After ADDR_L the pointer loads {ADDR_H, ADDR_L} modulo MEM_DEPTH, then → WR_DATA.
  - WR_DATA: 8 bits → ACK_WR. The byte is written to RAM[ptr] on the cycle after the 8th scl_rise, and wr_pulse fires. The pointer's low log2(PAGE_SIZE) bits increment and wrap within the page; the upper bits are unchanged. Then back to WR_DATA.
  - RD_DATA: the shift register loads RAM[ptr] during ACK_DEV (or during MACK of the previous byte). That load uses a synchronous RAM read, so the data is ready before the first scl_fall. Bits are driven MSB-first: oe = ~bit. The pointer increments modulo MEM_DEPTH after each byte → MACK.
  - MACK: sample SDA on scl_rise. 0 (ACK) → RD_DATA with the next byte. 1 (NACK) → WAIT_STOP with SDA released.
  - WAIT_STOP: ignore the bus until STOP or START.
- Random read = write-phase address, repeated START, then R/W=1. The pointer is preserved across START/STOP.
- Reset mid-operation: SDA is released within one sys_clk of reset assertion (asynchronous). The block resumes in IDLE.
- A partial byte interrupted by START/STOP is discarded, with no RAM write.

Optional Feature:
- Macro I2C_EEPROM_SLAVE_WP_EN.
- When defined: adds input port wp (1 bit, synchronised with 2 FF). While wp=1, WR_DATA bytes are NACKed, no RAM write occurs and wr_pulse stays 0. Address bytes are still ACKed.
- When undefined: no wp port, and all writes are accepted.

Decomposition:
- Package i2c_eeprom_pkg: state enum, ACK=1'b0/NACK=1'b1 constants, and a clog2-based ADDR_W/PAGE_W derivation.
- One sub-module, i2c_eeprom_ram: single-port MEM_DEPTH×8 RAM with synchronous write and registered read.

Test Plan:
- Write then read: write 0x000→0x11, 0x001→0x22, 0x002→0x33 (3 byte writes), then random read 3 bytes at 0x000 → master receives 11,22,33. Each address/data byte is ACKed and wr_pulse fires 3 times.
- Address mismatch: device address 0x51 → SDA stays high in the ACK slot, busy=0, no later bus activity until the next START.
- Page wrap: page write at 0x01E with bytes A0..A3 → RAM[0x1E]=A0, [0x1F]=A1, [0x00]=A2, [0x01]=A3.
- Sequential read wrap: current-address read starting at 0xFF for 3 bytes (MEM_DEPTH=256) → RAM[0xFF],[0x00],[0x01]. Master NACK on the last byte → SDA released, WAIT_STOP.
- Reset mid-read: assert sys_rst_n low while the block drives a 0 bit → iic_sda_oe=0 immediately. After release, a fresh transaction succeeds with ptr=0.
- WP (with I2C_EEPROM_SLAVE_WP_EN): wp=1, write 0x55 to 0x010 → data byte NACKed, read back returns the old value. With wp=0 the write succeeds.

Source files
------------

// File: rtl/i2c_eeprom_pkg.sv
// rtl/i2c_eeprom_pkg.sv - shared constants for the I2C EEPROM target
//
// Purpose: FSM state encodings, I2C acknowledge levels and the address
//          width helper used by the EEPROM target and its RAM.
// Ports:   none (package).
package i2c_eeprom_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_DEV_ADDR  = 4'd1;
  localparam logic [3:0] ST_ACK_DEV   = 4'd2;
  localparam logic [3:0] ST_ADDR_H    = 4'd3;
  localparam logic [3:0] ST_ACK_AH    = 4'd4;
  localparam logic [3:0] ST_ADDR_L    = 4'd5;
  localparam logic [3:0] ST_ACK_AL    = 4'd6;
  localparam logic [3:0] ST_WR_DATA   = 4'd7;
  localparam logic [3:0] ST_ACK_WR    = 4'd8;
  localparam logic [3:0] ST_RD_DATA   = 4'd9;
  localparam logic [3:0] ST_MACK      = 4'd10;
  localparam logic [3:0] ST_WAIT_STOP = 4'd11;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Index width for a power-of-2 depth; a depth of 1 still needs one bit.
  function automatic int calc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_eeprom_ram.sv
// rtl/i2c_eeprom_ram.sv - single-port byte RAM backing the EEPROM target
//
// Purpose: DEPTH x 8 storage, synchronous write, registered read.
//          A read during a write returns the old contents.
// Ports:
//   i_clk    in   clock
//   i_we     in   write enable
//   i_addr   in   byte address (shared by read and write)
//   i_wdata  in   write data
//   o_rdata  out  registered read data of i_addr from the previous cycle
module i2c_eeprom_ram
  import i2c_eeprom_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = calc_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// rtl/i2c_eeprom_slave.sv - oversampled I2C target emulating a 24C64-style EEPROM
//
// Purpose: device address match, 1/2-byte word address, byte/page write,
//          current-address, random and sequential read. SCL/SDA are
//          oversampled in the sys_clk domain.
// Optional: `define I2C_EEPROM_SLAVE_WP_EN adds write-protect input wp.
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   iic_scl     in   I2C clock from the master
//   iic_sda_i   in   SDA level seen on the pad
//   wp          in   write protect, 1 = NACK data bytes (WP build only)
//   iic_sda_oe  out  1 = pull SDA low
//   busy        out  high from matched START until STOP or NACK
//   wr_pulse    out  one-cycle pulse per byte committed to RAM
module i2c_eeprom_slave
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
  parameter logic       BIT_CTRL   = 1'b1,
  parameter int         MEM_DEPTH  = 256,
  parameter int         PAGE_SIZE  = 32
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic iic_scl,
  input  logic iic_sda_i,
`ifdef I2C_EEPROM_SLAVE_WP_EN
  input  logic wp,
`endif
  output logic iic_sda_oe,
  output logic busy,
  output logic wr_pulse
);

  localparam int ADDR_W = calc_w(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] PMASK   = ADDR_W'(PAGE_SIZE - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic              r_scl_s1, r_scl_s2, r_scl_d;
  logic              r_sda_s1, r_sda_s2, r_sda_d;
  logic              r_fall_d;
  logic [3:0]        r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_addr_h;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_rd;
  logic              r_nack;
  logic              r_oe;
  logic              r_busy;
  logic              r_wr_en;

  logic              w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic              w_start, w_stop, w_last_bit, w_wp;
  logic [7:0]        w_byte;
  logic [7:0]        w_rd_data;

`ifdef I2C_EEPROM_SLAVE_WP_EN
  logic r_wp_s1, r_wp_s2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wp_s1 <= 1'b0;
      r_wp_s2 <= 1'b0;
    end else begin
      r_wp_s1 <= wp;
      r_wp_s2 <= r_wp_s1;
    end
  end

  assign w_wp = r_wp_s2;
`else
  assign w_wp = 1'b0;
`endif

  // Synchronisers reset to the idle-bus level so release of reset is quiet.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
      r_fall_d <= 1'b0;
    end else begin
      r_scl_s1 <= iic_scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= iic_sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      r_fall_d <= w_scl_fall;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_sda_rise = r_sda_s2 & ~r_sda_d;
  assign w_sda_fall = ~r_sda_s2 & r_sda_d;
  assign w_start    = w_sda_fall & r_scl_s2;
  assign w_stop     = w_sda_rise & r_scl_s2;
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_byte     = {r_shift[6:0], r_sda_s2};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_addr_h  <= 8'h00;
      r_ptr     <= '0;
      r_rd      <= 1'b0;
      r_nack    <= ACK;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      // Commit cycle: r_shift holds the byte; advance within the page only.
      if (r_wr_en) begin
        r_ptr <= (r_ptr & ~PMASK) | ((r_ptr + PTR_ONE) & PMASK);
      end

      if (w_start) begin
        r_state   <= ST_DEV_ADDR;
        r_bit_cnt <= 3'd0;
        r_oe      <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_oe      <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        if (w_scl_rise) begin
          case (r_state)
            ST_DEV_ADDR, ST_ADDR_H, ST_ADDR_L, ST_WR_DATA: begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_nack <= ACK;
                case (r_state)
                  ST_DEV_ADDR: begin
                    if (w_byte[7:1] == SLAVE_ADDR) begin
                      r_state <= ST_ACK_DEV;
                      r_busy  <= 1'b1;
                      r_rd    <= w_byte[0];
                    end else begin
                      r_state <= ST_IDLE;
                      r_busy  <= 1'b0;
                    end
                  end
                  ST_ADDR_H: begin
                    r_addr_h <= w_byte;
                    r_state  <= ST_ACK_AH;
                  end
                  ST_ADDR_L: begin
                    r_ptr   <= ADDR_W'({r_addr_h, w_byte});
                    r_state <= ST_ACK_AL;
                  end
                  default: begin
                    r_nack  <= w_wp ? NACK : ACK;
                    r_wr_en <= ~w_wp;
                    r_state <= ST_ACK_WR;
                  end
                endcase
              end
            end
            ST_ACK_DEV: begin
              if (r_rd) begin
                // RAM output already reflects r_ptr; first bit goes out on the next fall.
                r_shift <= w_rd_data;
                r_state <= ST_RD_DATA;
              end else begin
                r_state <= BIT_CTRL ? ST_ADDR_H : ST_ADDR_L;
              end
            end
            ST_ACK_AH: r_state <= ST_ADDR_L;
            ST_ACK_AL: r_state <= ST_WR_DATA;
            ST_ACK_WR: r_state <= ST_WR_DATA;
            ST_RD_DATA: begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_ptr   <= r_ptr + PTR_ONE;
                r_state <= ST_MACK;
              end
            end
            ST_MACK: begin
              if (r_sda_s2 == ACK) begin
                r_shift <= w_rd_data;
                r_state <= ST_RD_DATA;
              end else begin
                r_state <= ST_WAIT_STOP;
                r_busy  <= 1'b0;
              end
            end
            default: ;
          endcase
        end

        // SDA only moves one cycle after SCL fall, while SCL is low.
        if (r_fall_d) begin
          case (r_state)
            ST_ACK_DEV, ST_ACK_AH, ST_ACK_AL, ST_ACK_WR: r_oe <= (r_nack == ACK);
            ST_RD_DATA: r_oe <= ~r_shift[3'd7 - r_bit_cnt];
            default:    r_oe <= 1'b0;
          endcase
        end
      end
    end
  end

  i2c_eeprom_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .i_clk   (sys_clk),
    .i_we    (r_wr_en),
    .i_addr  (r_ptr),
    .i_wdata (r_shift),
    .o_rdata (w_rd_data)
  );

  assign iic_sda_oe = r_oe;
  assign busy       = r_busy;
  assign wr_pulse   = r_wr_en;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb/tb_i2c_eeprom_slave.sv - directed bench for the I2C EEPROM target
module tb_i2c_eeprom_slave;

  localparam int T_Q = 100;
  localparam int T_H = 200;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic iic_scl   = 1'b1;
  logic sda_m     = 1'b1;
  wire  iic_sda_i;
  wire  iic_sda_oe;
  wire  busy;
  wire  wr_pulse;
`ifdef I2C_EEPROM_SLAVE_WP_EN
  logic wp = 1'b0;
`endif

  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  bit   oe_seen = 1'b0;
  logic rd_nak;
  logic [7:0] rd_buf [4];

  assign iic_sda_i = sda_m & ~iic_sda_oe;

  i2c_eeprom_slave dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .iic_scl    (iic_scl),
    .iic_sda_i  (iic_sda_i),
`ifdef I2C_EEPROM_SLAVE_WP_EN
    .wp         (wp),
`endif
    .iic_sda_oe (iic_sda_oe),
    .busy       (busy),
    .wr_pulse   (wr_pulse)
  );

  always #10 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (wr_pulse) wr_cnt++;
    if (iic_sda_oe) oe_seen = 1'b1;
  end

  task automatic bus_start();
    sda_m = 1'b1; #T_Q;
    iic_scl = 1'b1; #T_H;
    sda_m = 1'b0; #T_H;
    iic_scl = 1'b0; #T_Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #T_Q;
    iic_scl = 1'b1; #T_H;
    sda_m = 1'b1; #T_H;
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #T_Q;
    iic_scl = 1'b1; #T_H;
    iic_scl = 1'b0; #T_Q;
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #T_Q;
    iic_scl = 1'b1; #(T_H/2);
    b = iic_sda_i; #(T_H/2);
    iic_scl = 1'b0; #T_Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic nak);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(nak);
  endtask

  task automatic get_byte(input logic last, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(last);
  endtask

  task automatic set_addr(input logic [15:0] a, output logic nak_any);
    logic n0, n1, n2;
    bus_start();
    put_byte(8'hA0, n0);
    put_byte(a[15:8], n1);
    put_byte(a[7:0], n2);
    nak_any = n0 | n1 | n2;
  endtask

  task automatic read_n(input int n);
    bus_start();
    put_byte(8'hA1, rd_nak);
    for (int i = 0; i < n; i++) get_byte(i == n - 1, rd_buf[i]);
  endtask

  task automatic test_reset();
    #50;
    checks++; if (iic_sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", iic_sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
    #50;
    sys_rst_n = 1'b1;
    #200;
  endtask

  task automatic test_write_read();
    logic [7:0] wdat [3];
    logic nak;
    int w0;
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      set_addr(16'(k), nak);
      checks++; if (nak !== 1'b0) begin errors++; $display("FAIL wr_addr_ack[%0d]: got nak=%b want 0", k, nak); end
      put_byte(wdat[k], nak);
      checks++; if (nak !== 1'b0) begin errors++; $display("FAIL wr_data_ack[%0d]: got nak=%b want 0", k, nak); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy[%0d]: got %b want 1", k, busy); end
      bus_stop();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %b want 0", busy); end
    checks++; if (wr_cnt - w0 !== 3) begin errors++; $display("FAIL wr_pulse_count: got %0d want 3", wr_cnt - w0); end
    set_addr(16'h0000, nak);
    read_n(3);
    bus_stop();
    checks++; if ((nak | rd_nak) !== 1'b0) begin errors++; $display("FAIL rd_ack: got %b want 0", nak | rd_nak); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd_buf[k] !== wdat[k]) begin errors++; $display("FAIL rd_data[%0d]: got %h want %h", k, rd_buf[k], wdat[k]); end
    end
  endtask

  task automatic test_mismatch();
    logic nak, nak2;
    bus_start();
    put_byte(8'hA2, nak);
    checks++; if (nak !== 1'b1) begin errors++; $display("FAIL mismatch_ack: got %b want 1", nak); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b want 0", busy); end
    oe_seen = 1'b0;
    put_byte(8'h00, nak2);
    checks++; if (oe_seen !== 1'b0 || nak2 !== 1'b1) begin errors++; $display("FAIL mismatch_quiet: got oe_seen=%b nak=%b want 0/1", oe_seen, nak2); end
    bus_stop();
  endtask

  task automatic test_reset_mid_read();
    logic nak;
    set_addr(16'h0000, nak);
    bus_start();
    put_byte(8'hA1, nak);
    checks++; if (iic_sda_oe !== 1'b1) begin errors++; $display("FAIL midread_drive: got %b want 1", iic_sda_oe); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (iic_sda_oe !== 1'b0) begin errors++; $display("FAIL midread_reset_oe: got %b want 0", iic_sda_oe); end
    #99;
    sys_rst_n = 1'b1;
    sda_m = 1'b1; #T_Q;
    iic_scl = 1'b1; #T_H;
    read_n(1);
    bus_stop();
    checks++; if (rd_nak !== 1'b0 || rd_buf[0] !== 8'h11) begin errors++; $display("FAIL post_reset_read: got nak=%b data=%h want 0/11", rd_nak, rd_buf[0]); end
  endtask

  task automatic test_page_wrap();
    logic nak, nak_acc;
    int w0;
    w0 = wr_cnt;
    set_addr(16'h001E, nak_acc);
    for (int k = 0; k < 4; k++) begin
      put_byte(8'hA0 + 8'(k), nak);
      nak_acc = nak_acc | nak;
    end
    bus_stop();
    checks++; if (nak_acc !== 1'b0) begin errors++; $display("FAIL page_ack: got %b want 0", nak_acc); end
    checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL page_wr_count: got %0d want 4", wr_cnt - w0); end
    set_addr(16'h001E, nak);
    read_n(2);
    bus_stop();
    checks++; if (rd_buf[0] !== 8'hA0 || rd_buf[1] !== 8'hA1) begin errors++; $display("FAIL page_1e: got %h %h want a0 a1", rd_buf[0], rd_buf[1]); end
    set_addr(16'h0000, nak);
    read_n(2);
    bus_stop();
    checks++; if (rd_buf[0] !== 8'hA2 || rd_buf[1] !== 8'hA3) begin errors++; $display("FAIL page_00: got %h %h want a2 a3", rd_buf[0], rd_buf[1]); end
  endtask

  task automatic test_seq_wrap();
    logic nak;
    set_addr(16'h00FF, nak);
    put_byte(8'h5A, nak);
    bus_stop();
    set_addr(16'h00FF, nak);
    bus_stop();
    read_n(3);
    checks++; if (rd_buf[0] !== 8'h5A || rd_buf[1] !== 8'hA2 || rd_buf[2] !== 8'hA3) begin
      errors++; $display("FAIL seq_wrap: got %h %h %h want 5a a2 a3", rd_buf[0], rd_buf[1], rd_buf[2]);
    end
    checks++; if (iic_sda_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL seq_nack_release: got oe=%b busy=%b want 0/0", iic_sda_oe, busy); end
    bus_stop();
  endtask

`ifdef I2C_EEPROM_SLAVE_WP_EN
  task automatic test_wp();
    logic nak, nak_a;
    int w0;
    wp = 1'b0; #T_H;
    set_addr(16'h0010, nak);
    put_byte(8'h77, nak);
    bus_stop();
    wp = 1'b1; #T_H;
    w0 = wr_cnt;
    set_addr(16'h0010, nak_a);
    put_byte(8'h55, nak);
    bus_stop();
    checks++; if (nak_a !== 1'b0) begin errors++; $display("FAIL wp_addr_ack: got %b want 0", nak_a); end
    checks++; if (nak !== 1'b1) begin errors++; $display("FAIL wp_data_nack: got %b want 1", nak); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL wp_wr_count: got %0d want 0", wr_cnt - w0); end
    set_addr(16'h0010, nak);
    read_n(1);
    bus_stop();
    checks++; if (rd_buf[0] !== 8'h77) begin errors++; $display("FAIL wp_readback: got %h want 77", rd_buf[0]); end
    wp = 1'b0; #T_H;
    set_addr(16'h0010, nak);
    put_byte(8'h55, nak);
    bus_stop();
    checks++; if (nak !== 1'b0) begin errors++; $display("FAIL wp_off_ack: got %b want 0", nak); end
    set_addr(16'h0010, nak);
    read_n(1);
    bus_stop();
    checks++; if (rd_buf[0] !== 8'h55) begin errors++; $display("FAIL wp_off_readback: got %h want 55", rd_buf[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_mismatch();
    test_reset_mid_read();
    test_page_wrap();
    test_seq_wrap();
`ifdef I2C_EEPROM_SLAVE_WP_EN
    test_wp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
